// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control sequencer.
// Fetches into IR, classifies the opcode and walks each instruction through
// IDLE/FETCH/DECODE/EXEC/MEM/WB, driving immediate selects and datapath enables.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds oRetired / oStallCycles.
module multicycle_ctrl #(
    parameter int unsigned IMEM_TIMEOUT = 16,
    parameter int unsigned DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:1] iImemData,
    input  logic        iImemValid,
    output logic        oImemReq,
    input  logic        iDmemReady,
    output logic        oDmemReq,
    output logic        oDmemWe,
    input  logic        iBranchTaken,
    output logic [32:1] oInstr,
    output logic [2:0]  oInsTypeISB,
    output logic [1:0]  oInsTypeJU,
    output logic        oAluSrcImm,
    output logic        oPcWrite,
    output logic [1:0]  oPcSel,
    output logic        oRegWrite,
    output logic [1:0]  oResultSel,
    output logic        oTrap,
    output logic [2:0]  oState
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] oRetired,
    output logic [31:0] oStallCycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state;
    logic [32:1] ir;
    logic [31:0] wait_cnt;

    logic [6:0]  opcode;
    logic        is_r, is_ialu, is_load, is_store, is_branch;
    logic        is_jal, is_jalr, is_lui, is_auipc, legal;
    logic        fetch_wait, mem_wait, timeout_hit, active;

    assign opcode    = ir[7:1];
    assign is_r      = (opcode == OP_R);
    assign is_ialu   = (opcode == OP_IALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign legal     = is_r | is_ialu | is_load | is_store | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc;

    // A wait cycle is a FETCH/MEM cycle without its handshake; the handshake
    // always takes priority over an expiring limit. A limit of 0 never expires.
    assign fetch_wait  = (state == S_FETCH) && !iImemValid;
    assign mem_wait    = (state == S_MEM) && !iDmemReady;
    assign timeout_hit = (fetch_wait && (IMEM_TIMEOUT != 32'd0) &&
                          (wait_cnt + 32'd1 == IMEM_TIMEOUT)) ||
                         (mem_wait && (DMEM_TIMEOUT != 32'd0) &&
                          (wait_cnt + 32'd1 == DMEM_TIMEOUT));

    assign active = (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM) || (state == S_WB);

    assign oInstr = ir;
    assign oState = state;

    // Sequencer: state, instruction register and the shared wait counter.
    // The counter returns to zero on every cycle that is not a stalled wait,
    // so it restarts from zero on each FETCH/MEM entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (iImemValid) begin
                        ir    <= iImemData;
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DECODE: state <= legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    if (is_branch)                state <= S_FETCH;
                    else if (is_load || is_store) state <= S_MEM;
                    else                          state <= S_WB;
                end
                S_MEM: begin
                    if (iDmemReady) begin
                        state <= is_store ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB:     state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_TRAP;
            endcase
        end
    end

    // Output decode from state and IR; the BRANCH and STORE PC strobes also
    // look at the ALU compare and memory ready of the current cycle.
    always_comb begin
        oImemReq    = 1'b0;
        oDmemReq    = 1'b0;
        oDmemWe     = 1'b0;
        oInsTypeISB = 3'b000;
        oInsTypeJU  = 2'b00;
        oAluSrcImm  = 1'b0;
        oPcWrite    = 1'b0;
        oPcSel      = 2'b00;
        oRegWrite   = 1'b0;
        oResultSel  = 2'b00;
        oTrap       = 1'b0;
        if (active) begin
            if (is_ialu || is_load || is_jalr) oInsTypeISB = 3'b001;
            else if (is_store)                 oInsTypeISB = 3'b010;
            else if (is_branch)                oInsTypeISB = 3'b100;
            if (is_jal)                        oInsTypeJU  = 2'b01;
            else if (is_lui || is_auipc)       oInsTypeJU  = 2'b10;
        end
        case (state)
            S_FETCH: oImemReq = 1'b1;
            S_EXEC: begin
                oAluSrcImm = !(is_r || is_branch);
                if (is_branch) begin
                    oPcWrite = 1'b1;
                    oPcSel   = iBranchTaken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                oDmemReq   = 1'b1;
                oDmemWe    = is_store;
                oAluSrcImm = 1'b1;
                oPcWrite   = is_store && iDmemReady;
            end
            S_WB: begin
                oRegWrite = 1'b1;
                oPcWrite  = 1'b1;
                if (is_jal)       oPcSel = 2'b01;
                else if (is_jalr) oPcSel = 2'b10;
                if (is_load)                oResultSel = 2'b01;
                else if (is_jal || is_jalr) oResultSel = 2'b10;
                else if (is_lui)            oResultSel = 2'b11;
            end
            S_TRAP:  oTrap = 1'b1;
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Performance counters: retired instructions and handshake stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oRetired     <= '0;
            oStallCycles <= '0;
        end else begin
            if (oPcWrite)               oRetired     <= oRetired + 32'd1;
            if (fetch_wait || mem_wait) oStallCycles <= oStallCycles + 32'd1;
        end
    end
`endif

endmodule
